// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
//
// Keeps a byte program counter and reads one 32-bit word per cycle from a
// combinational instruction memory. Each fetched {pc, word} pair goes into a
// 2-entry FIFO, and the consumer drains that FIFO. A redirect (branch/jump)
// flushes the FIFO and restarts fetch at the target address. Fetch halts, and
// raises fault, when the pc leaves the memory or a redirect target is
// misaligned. Queued entries still drain while fetch is halted.
//
// Ports:
//   clk, rst_n      clock; asynchronous active-low reset
//   imem_addr       word index to memory (pc[31:2]), combinational from pc
//   imem_data       word returned by memory for imem_addr
//   redirect_valid  restart fetch at redirect_pc (flushes the queue)
//   redirect_pc     byte address of the redirect target
//   inst_valid      queue head holds a valid instruction
//   inst_ready      consumer accepts the head this cycle
//   inst_out        instruction word at the queue head
//   inst_pc         byte address of inst_out
//   fault           fetch halted on an illegal pc (also the FSM state)
//
// Handshake: the head transfers on every rising edge where inst_valid and
// inst_ready are both 1. While inst_valid=1 and inst_ready=0, inst_out and
// inst_pc hold their values. A redirect in the same cycle discards that
// transfer.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned MEM_WORDS = 1 << 20
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_out,
   output logic [31:0] inst_pc,
   output logic        fault
);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [31:0] pc;
   // Entry 0 is the head. Entry 1 moves into entry 0 on a pop.
   logic [31:0] e0_pc, e0_inst, e1_pc, e1_inst;
   logic [1:0]  count;

   logic        pop;
   logic        push;
   logic        pc_legal;

   assign imem_addr  = {2'b00, pc[31:2]};
   assign inst_valid = (count != 2'd0);
   assign inst_out   = e0_inst;
   assign inst_pc    = e0_pc;

   assign pop      = inst_valid && inst_ready;
   assign pc_legal = ({2'b00, pc[31:2]} < MEM_WORDS);
   // A full FIFO may still accept a push when its head leaves on the same edge.
   assign push     = (state == ST_RUN) && !redirect_valid && pc_legal &&
                     ((count != 2'd2) || pop);

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_RUN;
      end else begin
         state <= state_next;
      end
   end

   // FSM next state: a redirect overrides everything. An aligned target
   // resumes fetch; a misaligned target halts it.
   always_comb begin
      state_next = state;
      if (redirect_valid) begin
         state_next = (redirect_pc[1:0] == 2'b00) ? ST_RUN : ST_HALT;
      end else if ((state == ST_RUN) && !pc_legal) begin
         state_next = ST_HALT;
      end
   end

   // FSM outputs
   always_comb begin
      fault = 1'b0;
      if (state == ST_HALT) begin
         fault = 1'b1;
      end
   end

   // pc and FIFO datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc      <= RESET_PC;
         count   <= 2'd0;
         e0_pc   <= 32'd0;
         e0_inst <= 32'd0;
         e1_pc   <= 32'd0;
         e1_inst <= 32'd0;
      end else if (redirect_valid) begin
         pc    <= redirect_pc;
         count <= 2'd0;
      end else begin
         if (push) begin
            pc <= pc + 32'd4;
         end
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) begin
                  e0_pc   <= pc;
                  e0_inst <= imem_data;
               end else begin
                  e1_pc   <= pc;
                  e1_inst <= imem_data;
               end
               count <= count + 2'd1;
            end
            2'b01: begin
               e0_pc   <= e1_pc;
               e0_inst <= e1_inst;
               count   <= count - 2'd1;
            end
            2'b11: begin
               // The count stays the same. The new word goes behind any
               // entry that remains.
               if (count == 2'd1) begin
                  e0_pc   <= pc;
                  e0_inst <= imem_data;
               end else begin
                  e0_pc   <= e1_pc;
                  e0_inst <= e1_inst;
                  e1_pc   <= pc;
                  e1_inst <= imem_data;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC    = 32'h0000_0000;
   localparam int unsigned BIG_WORDS   = 1 << 20;
   localparam int unsigned SMALL_WORDS = 4;

   typedef logic [63:0] ent_q_t[$];

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        inst_ready = 1'b0;

   // dut_b: default memory size; dut_s: 4-word memory for the illegal-pc case
   logic [31:0] addr_b, data_b, out_b, ipc_b;
   logic        iv_b, flt_b;
   logic [31:0] addr_s, data_s, out_s, ipc_s;
   logic        iv_s, flt_s;

   assign data_b = 32'h1000_0000 + addr_b;
   assign data_s = 32'h1000_0000 + addr_s;

   fetch_unit #(.RESET_PC(RESET_PC), .MEM_WORDS(BIG_WORDS)) dut_b (
      .clk(clk), .rst_n(rst_n), .imem_addr(addr_b), .imem_data(data_b),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(iv_b), .inst_ready(inst_ready), .inst_out(out_b),
      .inst_pc(ipc_b), .fault(flt_b)
   );

   fetch_unit #(.RESET_PC(RESET_PC), .MEM_WORDS(SMALL_WORDS)) dut_s (
      .clk(clk), .rst_n(rst_n), .imem_addr(addr_s), .imem_data(data_s),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(iv_s), .inst_ready(inst_ready), .inst_out(out_s),
      .inst_pc(ipc_s), .fault(flt_s)
   );

   // ---------------- scoreboard / reference model ----------------
   int n_checks = 0;
   int n_errors = 0;

   ent_q_t      exp_q_b, exp_q_s;     // expected queue contents, head first
   logic [31:0] pc_b, pc_s;
   logic        halt_b, halt_s;
   logic [31:0] log_b[$], log_s[$];   // inst_pc values handed over by each DUT

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h1000_0000 + (a >> 2);
   endfunction

   // One clock edge of the fetch unit's behaviour, expressed as queue operations.
   task automatic model_step(inout ent_q_t q, inout logic [31:0] pc, inout logic halt,
                             input int unsigned mw, input logic rv,
                             input logic [31:0] rpc, input logic rdy);
      if (rv) begin
         q.delete();
         pc   = rpc;
         halt = (rpc[1:0] != 2'b00);
      end else begin
         if (q.size() > 0 && rdy) void'(q.pop_front());
         if (!halt) begin
            if ((pc >> 2) >= mw) begin
               halt = 1'b1;
            end else if (q.size() < 2) begin
               q.push_back({pc, mem_word(pc)});
               pc = pc + 32'd4;
            end
         end
      end
   endtask

   task automatic model_reset();
      exp_q_b.delete(); exp_q_s.delete();
      pc_b = RESET_PC;  pc_s = RESET_PC;
      halt_b = 1'b0;    halt_s = 1'b0;
   endtask

   task automatic check_dut(input string n, input ent_q_t q, input logic [31:0] pc,
                            input logic halt, input logic iv, input logic flt,
                            input logic [31:0] ia, input logic [31:0] io,
                            input logic [31:0] ipc);
      check({n, ".valid"}, 32'(iv), 32'(q.size() > 0));
      check({n, ".fault"}, 32'(flt), 32'(halt));
      check({n, ".imem_addr"}, ia, pc >> 2);
      if (q.size() > 0) begin
         check({n, ".inst_pc"}, ipc, q[0][63:32]);
         check({n, ".inst_out"}, io, q[0][31:0]);
      end
   endtask

   task automatic check_all(input string tag);
      check_dut({tag, ".b"}, exp_q_b, pc_b, halt_b, iv_b, flt_b, addr_b, out_b, ipc_b);
      check_dut({tag, ".s"}, exp_q_s, pc_s, halt_s, iv_s, flt_s, addr_s, out_s, ipc_s);
   endtask

   // ---------------- driver tasks ----------------
   task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
      redirect_valid = rv;
      redirect_pc    = rpc;
      inst_ready     = rdy;
      if (!rv && rdy && iv_b) log_b.push_back(ipc_b);
      if (!rv && rdy && iv_s) log_s.push_back(ipc_s);
      @(posedge clk);
      model_step(exp_q_b, pc_b, halt_b, BIG_WORDS, rv, rpc, rdy);
      model_step(exp_q_s, pc_s, halt_s, SMALL_WORDS, rv, rpc, rdy);
      #1;
      check_all("step");
   endtask

   // Reset is asserted between edges; outputs must clear without a clock edge.
   task automatic async_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("rst.valid_now", 32'(iv_b), 32'd0);
      check("rst.inst_out", out_b, 32'd0);
      check("rst.inst_pc", ipc_b, 32'd0);
      check_all("rst");
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      check_all("rst_rel");
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] t;
      int r;
      model_reset();
      #3;
      check_all("reset");
      check("reset.inst_out", out_b, 32'd0);
      @(posedge clk);
      #1;
      check_all("reset_edge");
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      #1;

      // Streaming from reset with the consumer always ready.
      log_b.delete();
      for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b1);
      check("stream.head_pc", ipc_b, 32'd12);
      check("stream.n_taken", 32'(log_b.size()), 32'd3);
      for (int i = 0; i < log_b.size(); i++) check("stream.seq", log_b[i], 32'(i * 4));

      // Backpressure: the consumer stalls for 5 cycles, then drains.
      async_reset();
      for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 1'b0);
      check("bp.imem_addr", addr_b, 32'd2);
      check("bp.head_pc", ipc_b, 32'd0);
      log_b.delete();
      for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b1);
      check("bp.n_taken", 32'(log_b.size()), 32'd3);
      for (int i = 0; i < log_b.size(); i++) check("bp.seq", log_b[i], 32'(i * 4));

      // Redirect while the FIFO is full and the consumer is ready.
      step(1'b1, 32'h40, 1'b1);
      step(1'b0, 32'd0, 1'b1);
      check("redir.head_pc", ipc_b, 32'h40);
      log_b.delete();
      step(1'b0, 32'd0, 1'b1);
      check("redir.first_after", log_b.size() > 0 ? log_b[0] : 32'hDEAD_BEEF, 32'h40);

      // Misaligned redirect.
      step(1'b1, 32'h22, 1'b1);
      check("misal.fault", 32'(flt_b), 32'd1);
      check("misal.valid", 32'(iv_b), 32'd0);

      // Illegal fetch on the 4-word instance, then recovery by redirect.
      step(1'b1, 32'd0, 1'b1);
      log_s.delete();
      for (int i = 0; i < 8; i++) step(1'b0, 32'd0, 1'b1);
      check("illegal.n_taken", 32'(log_s.size()), 32'd4);
      for (int i = 0; i < log_s.size(); i++) check("illegal.seq", log_s[i], 32'(i * 4));
      check("illegal.fault", 32'(flt_s), 32'd1);
      check("illegal.valid", 32'(iv_s), 32'd0);
      check("illegal.pc", addr_s, 32'd4);
      step(1'b1, 32'd0, 1'b1);
      check("illegal.cleared", 32'(flt_s), 32'd0);

      // Mid-run reset with two entries queued.
      step(1'b0, 32'd0, 1'b0);
      step(1'b0, 32'd0, 1'b0);
      step(1'b0, 32'd0, 1'b0);
      async_reset();
      step(1'b0, 32'd0, 1'b1);
      check("mrst.first_pc", ipc_b, RESET_PC);

      // Randomized traffic against the model.
      for (int i = 0; i < 500; i++) begin
         r = $urandom_range(0, 99);
         if (r < 2) begin
            async_reset();
         end else if (r < 10) begin
            case ($urandom_range(0, 3))
               0: t = 32'($urandom_range(0, 7)) << 2;
               1: t = 32'($urandom_range(0, 63)) << 2;
               2: t = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
               default: t = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
            endcase
            step(1'b1, t, 1'($urandom_range(0, 1)));
         end else begin
            step(1'b0, 32'd0, 1'($urandom_range(0, 3) != 0));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
